de10_bus_router: RTL
====================

# de10_bus_router

Parametrised bus address router between the single CPU bus master and `NUM_SLAVES` bus slaves (SDRAM, peripheral bridge, boot ROM, …) on the DE10-Lite. It decodes each request's upper address bits against a per-slave region tag and steers the access to exactly one slave. It then returns that slave's acknowledge and read data to the master. Unmapped addresses and accesses to slaves that never respond end with an error acknowledge, so the CPU never hangs. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `NUM_SLAVES`, default 2: number of slave ports, 1..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TAG_W`, default 10: number of upper address bits compared (`addr[ADDR_W-1 -: TAG_W]`).
- `REGION_TAGS`, default `{10'h001, 10'h000}`: `NUM_SLAVES*TAG_W` bits; the tag for slave i is `[i*TAG_W +: TAG_W]`.
- `TIMEOUT`, default 255: maximum cycles in ACCESS before an error response; 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `m_req`  in  1  master request, sampled in IDLE only.
- `m_we`  in  1  1 = write, 0 = read.
- `m_addr`  in  ADDR_W  request address.
- `m_wdata`  in  DATA_W  write data.
- `m_ack`  out  1  one-cycle completion pulse.
- `m_err`  out  1  error flag, valid with `m_ack`.
- `m_rdata`  out  DATA_W  read data, valid with `m_ack`; 0 otherwise.
- `s_sel`  out  NUM_SLAVES  one-hot slave select, held through ACCESS.
- `s_we`, `s_addr`, `s_wdata`  out  1/ADDR_W/DATA_W  latched request fields, broadcast to all slaves.
- `s_ack`  in  NUM_SLAVES  per-slave acknowledge.
- `s_rdata`  in  NUM_SLAVES*DATA_W  per-slave read data; slave i at `[i*DATA_W +: DATA_W]`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE, `m_req`=1:**
  - Latch `m_we`, `m_addr` and `m_wdata` into the `s_*` registers.
  - Decode the tag. If several tags match, the lowest index wins.
  - On a match: the next state is ACCESS, `s_sel` is one-hot at index i, and the timeout counter clears to 0.
  - On no match: the next state is RESP with `err`=1 and `rdata`=0. No slave is selected.
- **ACCESS:**
  - Only `s_ack[i]` of the selected slave is honoured; acks from other slaves are ignored.
  - On `s_ack[i]`=1: capture `s_rdata[i]` (writes capture 0), set `err`=0, clear `s_sel`, and go to RESP.
  - Otherwise the counter increments. If `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1 without an ack: clear `s_sel`, set `err`=1 and `rdata`=0, and go to RESP.
  - `TIMEOUT`=0 means the router waits indefinitely.
- **RESP:** `m_ack`=1 for exactly one cycle, with `m_err` and `m_rdata` driven from the captured values. The next state is IDLE.
- Master inputs are ignored outside IDLE. If `m_req` is still high in the IDLE cycle after an ack, it is treated as a new transaction (back-to-back issue is legal).
- Counter width is `$clog2(TIMEOUT+1)` (minimum 1 bit). The counter saturates and never wraps.

## Timing
- Reset values: state IDLE; `m_ack`, `m_err`, `m_rdata`, `s_sel`, `s_we`, `s_addr`, `s_wdata`, `busy` and the counter are all 0.
- All outputs are registered. There is no combinational path from `m_*` or `s_ack` to any output.
- Mapped access with the ack in the first ACCESS cycle:
  - Request sampled at edge 0.
  - `s_sel` high during cycle 1, `s_ack` sampled at edge 1.
  - `m_ack` high during cycle 2.
  - Minimum latency is 2 cycles; an ack delay of k cycles adds k.
- Unmapped access: `m_ack`=`m_err`=1 during cycle 1.
- Timeout: `s_sel` high for exactly `TIMEOUT` cycles, then `m_ack`/`m_err` in the following cycle.
- Minimum spacing between requests is 3 cycles for mapped accesses and 2 cycles for unmapped accesses.
- `rst` asserted in any state forces IDLE at the next edge. `s_sel` drops, and no `m_ack` is issued for the aborted transaction.

## Test plan
- Read `m_addr`=0x0000_0010, slave 0 acks one cycle after `s_sel` with rdata 0xDEADBEEF -> `s_sel`=2'b01 and `s_addr`=0x10; `m_ack`=1, `m_err`=0, `m_rdata`=0xDEADBEEF exactly once, 3 cycles after the request.
- Write `m_addr`=0x0040_0004, wdata 0x55 -> `s_sel`=2'b10, `s_we`=1, `s_wdata`=0x55; on ack, `m_rdata`=0 and `m_err`=0.
- Address 0xFFC0_0000 (tag 0x3FF, unmapped) -> `s_sel` never asserts; `m_ack`=`m_err`=1 during the cycle after the request.
- `TIMEOUT`=4, slave 1 never acks -> `s_sel`=2'b10 for exactly 4 cycles, then `m_ack`=`m_err`=1 and `m_rdata`=0; returns to IDLE.
- Slave 1 pulses `s_ack` while slave 0 is selected -> ignored; only slave 0's later ack completes the transaction.
- `rst` pulsed during ACCESS -> `s_sel`=0 and `busy`=0 after the edge; no `m_ack`; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/de10_bus_router.sv
// Single-master address router: decodes the upper address tag, steers one
// transaction at a time to a slave and returns ack/err/rdata to the CPU.
module de10_bus_router #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 10,
  parameter logic [NUM_SLAVES*TAG_W-1:0] REGION_TAGS = {10'h001, 10'h000},
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic                         busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q;
  logic [NUM_SLAVES-1:0]   s_sel_q;
  logic                    s_we_q;
  logic [ADDR_W-1:0]       s_addr_q;
  logic [DATA_W-1:0]       s_wdata_q;
  logic                    m_ack_q, m_err_q;
  logic [DATA_W-1:0]       m_rdata_q;
  logic [CW-1:0]           cnt_q;

  logic [NUM_SLAVES-1:0]   match;
  logic [NUM_SLAVES-1:0]   sel_d;
  logic [DATA_W-1:0]       rdata_d;
  logic                    ack_hit;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_tag
    assign match[g] = (m_addr[ADDR_W-1 -: TAG_W] == REGION_TAGS[g*TAG_W +: TAG_W]);
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    sel_d = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_d    = '0;
        sel_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel_q[i]) rdata_d = s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign ack_hit = |(s_ack & s_sel_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_req) begin
            s_we_q    <= m_we;
            s_addr_q  <= m_addr;
            s_wdata_q <= m_wdata;
            cnt_q     <= '0;
            if (|sel_d) begin
              s_sel_q <= sel_d;
              state_q <= ACCESS;
            end else begin
              m_ack_q   <= 1'b1;
              m_err_q   <= 1'b1;
              m_rdata_q <= '0;
              state_q   <= RESP;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            m_ack_q   <= 1'b1;
            m_err_q   <= 1'b0;
            m_rdata_q <= s_we_q ? '0 : rdata_d;
            s_sel_q   <= '0;
            state_q   <= RESP;
          end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
            m_ack_q   <= 1'b1;
            m_err_q   <= 1'b1;
            m_rdata_q <= '0;
            s_sel_q   <= '0;
            state_q   <= RESP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          m_ack_q   <= 1'b0;
          m_err_q   <= 1'b0;
          m_rdata_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign busy    = (state_q != IDLE);

endmodule
